// File: rtl/udp1_rx_if.sv
// GMII receive / UDP payload bundle for udp1_rx.
// slave: the receiver itself; master: the GMII source and payload consumer side.
interface udp1_rx_if;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        rec_en;
  logic [7:0]  rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  modport slave (
    input  gmii_rx_dv, gmii_rxd,
    output rec_en, rec_data, rec_pkt_done, rec_byte_num, src_mac, src_ip
  );

  modport master (
    output gmii_rx_dv, gmii_rxd,
    input  rec_en, rec_data, rec_pkt_done, rec_byte_num, src_mac, src_ip
  );
endinterface

// File: rtl/udp1_rx.sv
// GMII UDP/IPv4 receiver: strips preamble/Ethernet/IPv4/UDP headers, streams the payload.
// Optional UDP_RX_PORT_FILTER_EN: also require UDP dest port == BOARD_PORT.
module udp1_rx #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd123},
  parameter logic [15:0] BOARD_PORT = 16'd1234
) (
  input logic       clk,
  input logic       rst_n,
  udp1_rx_if.slave  bus
);

`ifdef UDP_RX_PORT_FILTER_EN
  localparam bit PORT_FILTER = 1'b1;
`else
  localparam bit PORT_FILTER = 1'b0;
`endif

  typedef enum logic [6:0] {
    st_idle     = 7'b000_0001,
    st_preamble = 7'b000_0010,
    st_eth_head = 7'b000_0100,
    st_ip_head  = 7'b000_1000,
    st_udp_head = 7'b001_0000,
    st_rx_data  = 7'b010_0000,
    st_rx_end   = 7'b100_0000
  } state_t;

  state_t      state_r, state_nx_s;
  logic [15:0] cnt_r, cnt_nx_s;
  logic [15:0] data_num_r, data_num_nx_s;
  logic [39:0] sh_r;
  logic [47:0] mac_stage_r, mac_stage_nx_s;
  logic [31:0] ip_stage_r, ip_stage_nx_s;
  logic        rec_en_r, rec_en_nx_s;
  logic [7:0]  rec_data_r, rec_data_nx_s;
  logic        done_r, done_nx_s;
  logic [15:0] byte_num_r, byte_num_nx_s;
  logic [47:0] src_mac_r, src_mac_nx_s;
  logic [31:0] src_ip_r, src_ip_nx_s;

  logic        dv_s;
  logic [7:0]  rxd_s;
  logic [47:0] word48_s;
  logic [31:0] word32_s;
  logic [15:0] word16_s;
  logic        mac_ok_s;

  // Multi-byte header fields end on the current byte; earlier bytes come from the shift history.
  assign dv_s     = bus.gmii_rx_dv;
  assign rxd_s    = bus.gmii_rxd;
  assign word48_s = {sh_r, rxd_s};
  assign word32_s = {sh_r[23:0], rxd_s};
  assign word16_s = {sh_r[7:0], rxd_s};
  assign mac_ok_s = (word48_s == BOARD_MAC) || (word48_s == 48'hffff_ffff_ffff);

  // State, counters, header history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= st_idle;
      cnt_r       <= 16'd0;
      data_num_r  <= 16'd0;
      sh_r        <= 40'd0;
      mac_stage_r <= 48'd0;
      ip_stage_r  <= 32'd0;
      rec_en_r    <= 1'b0;
      rec_data_r  <= 8'd0;
      done_r      <= 1'b0;
      byte_num_r  <= 16'd0;
      src_mac_r   <= 48'd0;
      src_ip_r    <= 32'd0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      data_num_r  <= data_num_nx_s;
      sh_r        <= {sh_r[31:0], rxd_s};
      mac_stage_r <= mac_stage_nx_s;
      ip_stage_r  <= ip_stage_nx_s;
      rec_en_r    <= rec_en_nx_s;
      rec_data_r  <= rec_data_nx_s;
      done_r      <= done_nx_s;
      byte_num_r  <= byte_num_nx_s;
      src_mac_r   <= src_mac_nx_s;
      src_ip_r    <= src_ip_nx_s;
    end
  end

  // Next-state and next-output logic; a dv drop mid-frame aborts without a done pulse.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    data_num_nx_s  = data_num_r;
    mac_stage_nx_s = mac_stage_r;
    ip_stage_nx_s  = ip_stage_r;
    rec_en_nx_s    = 1'b0;
    rec_data_nx_s  = rec_data_r;
    done_nx_s      = 1'b0;
    byte_num_nx_s  = byte_num_r;
    src_mac_nx_s   = src_mac_r;
    src_ip_nx_s    = src_ip_r;

    case (state_r)
      st_idle: begin
        if (dv_s && (rxd_s == 8'h55)) begin
          state_nx_s = st_preamble;
          cnt_nx_s   = 16'd1;
        end else begin
          state_nx_s = st_idle;
        end
      end

      st_preamble: begin
        if (!dv_s) begin
          state_nx_s = st_idle;
        end else if (rxd_s == 8'h55) begin
          cnt_nx_s = (cnt_r == 16'hffff) ? cnt_r : cnt_r + 16'd1;
        end else if ((rxd_s == 8'hd5) && (cnt_r >= 16'd7)) begin
          state_nx_s = st_eth_head;
          cnt_nx_s   = 16'd0;
        end else begin
          state_nx_s = st_rx_end;
        end
      end

      st_eth_head: begin
        cnt_nx_s = cnt_r + 16'd1;
        if (!dv_s) begin
          state_nx_s = st_idle;
        end else if ((cnt_r == 16'd5) && !mac_ok_s) begin
          state_nx_s = st_rx_end;
        end else if (cnt_r == 16'd11) begin
          mac_stage_nx_s = word48_s;
        end else if (cnt_r == 16'd13) begin
          state_nx_s = (word16_s == 16'h0800) ? st_ip_head : st_rx_end;
          cnt_nx_s   = 16'd0;
        end else begin
          state_nx_s = st_eth_head;
        end
      end

      st_ip_head: begin
        cnt_nx_s = cnt_r + 16'd1;
        if (!dv_s) begin
          state_nx_s = st_idle;
        end else if ((cnt_r == 16'd0) && (rxd_s != 8'h45)) begin
          state_nx_s = st_rx_end;
        end else if ((cnt_r == 16'd9) && (rxd_s != 8'd17)) begin
          state_nx_s = st_rx_end;
        end else if (cnt_r == 16'd15) begin
          ip_stage_nx_s = word32_s;
        end else if (cnt_r == 16'd19) begin
          state_nx_s = (word32_s == BOARD_IP) ? st_udp_head : st_rx_end;
          cnt_nx_s   = 16'd0;
        end else begin
          state_nx_s = st_ip_head;
        end
      end

      st_udp_head: begin
        cnt_nx_s = cnt_r + 16'd1;
        if (!dv_s) begin
          state_nx_s = st_idle;
        end else if ((cnt_r == 16'd3) && PORT_FILTER && (word16_s != BOARD_PORT)) begin
          state_nx_s = st_rx_end;
        end else if (cnt_r == 16'd5) begin
          data_num_nx_s = word16_s - 16'd8;
          state_nx_s    = (word16_s < 16'd8) ? st_rx_end : st_udp_head;
        end else if (cnt_r == 16'd7) begin
          cnt_nx_s = 16'd0;
          if (data_num_r == 16'd0) begin
            done_nx_s     = 1'b1;
            byte_num_nx_s = 16'd0;
            src_mac_nx_s  = mac_stage_r;
            src_ip_nx_s   = ip_stage_r;
            state_nx_s    = st_rx_end;
          end else begin
            state_nx_s = st_rx_data;
          end
        end else begin
          state_nx_s = st_udp_head;
        end
      end

      st_rx_data: begin
        if (!dv_s) begin
          state_nx_s = st_idle;
        end else begin
          rec_en_nx_s   = 1'b1;
          rec_data_nx_s = rxd_s;
          cnt_nx_s      = cnt_r + 16'd1;
          if (cnt_r == data_num_r - 16'd1) begin
            done_nx_s     = 1'b1;
            byte_num_nx_s = data_num_r;
            src_mac_nx_s  = mac_stage_r;
            src_ip_nx_s   = ip_stage_r;
            state_nx_s    = st_rx_end;
          end else begin
            state_nx_s = st_rx_data;
          end
        end
      end

      st_rx_end: begin
        state_nx_s = dv_s ? st_rx_end : st_idle;
      end

      default: begin
        state_nx_s = st_idle;
      end
    endcase
  end

  assign bus.rec_en       = rec_en_r;
  assign bus.rec_data     = rec_data_r;
  assign bus.rec_pkt_done = done_r;
  assign bus.rec_byte_num = byte_num_r;
  assign bus.src_mac      = src_mac_r;
  assign bus.src_ip       = src_ip_r;

endmodule

// File: tb/tb_udp1_rx.sv
// Directed bench for udp1_rx: frames are built from header fields, a frame-level model
// derives the per-cycle expected outputs, and a compare process checks every cycle.
module tb_udp1_rx;

  localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BIP  = 32'hc0a8017b;
  localparam logic [47:0] SMAC = 48'ha0_b1_c2_d3_e4_f5;
  localparam logic [31:0] SIP  = 32'hc0a80166;
`ifdef UDP_RX_PORT_FILTER_EN
  localparam bit PORT_FILT = 1'b1;
`else
  localparam bit PORT_FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #4 clk = ~clk;

  udp1_rx_if bus();
  udp1_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        en;
    logic [7:0]  data;
    logic        done;
    logic [15:0] num;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  int          n_chk = 0;
  int          n_fail = 0;
  int          strobes = 0;
  int          dones = 0;
  logic [15:0] m_num = 16'd0;
  logic [47:0] m_mac = 48'd0;
  logic [31:0] m_ip  = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One expectation per driven cycle, checked just after the edge that consumed it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("rec_en", bus.rec_en, ce.en);
      if (ce.en) chk("rec_data", bus.rec_data, ce.data);
      chk("rec_pkt_done", bus.rec_pkt_done, ce.done);
      if (ce.done) begin
        m_num = ce.num;
        m_mac = SMAC;
        m_ip  = SIP;
      end
      chk("rec_byte_num", bus.rec_byte_num, m_num);
      chk("src_mac", bus.src_mac, m_mac);
      chk("src_ip", bus.src_ip, m_ip);
      if (bus.rec_en) strobes++;
      if (bus.rec_pkt_done) dones++;
    end
  end

  task automatic idle(input int n);
    exp_t e;
    e.en = 1'b0; e.data = 8'd0; e.done = 1'b0; e.num = 16'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rxd   = 8'd0;
      exp_q.push_back(e);
    end
  endtask

  // cut < 0 sends the whole frame; ifg idle cycles follow (0 leaves dv high).
  task automatic send_frame(input int pre_n, input logic [47:0] dmac, input logic [15:0] etype,
                            input logic [7:0] ver, input logic [7:0] proto, input logic [31:0] dip,
                            input logic [15:0] dport, input logic [15:0] ulen,
                            input logic [7:0] base, input logic [7:0] step,
                            input int cut, input int ifg);
    logic [7:0]  fb[$];
    logic [15:0] tot;
    logic [7:0]  pb;
    exp_t        e;
    int          plen, hdr, n;
    bit          acc;
    plen = (ulen >= 16'd8) ? int'(ulen) - 8 : 0;
    tot  = 16'd20 + ulen;
    for (int i = 0; i < pre_n; i++) fb.push_back(8'h55);
    fb.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) fb.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(SMAC[i*8 +: 8]);
    fb.push_back(etype[15:8]); fb.push_back(etype[7:0]);
    fb.push_back(ver); fb.push_back(8'h00); fb.push_back(tot[15:8]); fb.push_back(tot[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h40); fb.push_back(8'h00);
    fb.push_back(8'h40); fb.push_back(proto); fb.push_back(8'h00); fb.push_back(8'h00);
    for (int i = 3; i >= 0; i--) fb.push_back(SIP[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fb.push_back(dip[i*8 +: 8]);
    fb.push_back(8'h1f); fb.push_back(8'h90);
    fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
    fb.push_back(ulen[15:8]); fb.push_back(ulen[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    pb = base;
    for (int i = 0; i < plen; i++) begin
      fb.push_back(pb);
      pb = pb + step;
    end
    while (fb.size() - (pre_n + 1) < 60) fb.push_back(8'haa);
    fb.push_back(8'hde); fb.push_back(8'had); fb.push_back(8'hbe); fb.push_back(8'hef);

    hdr = pre_n + 1 + 42;
    acc = (pre_n >= 7) && ((dmac == BMAC) || (dmac == 48'hffff_ffff_ffff)) &&
          (etype == 16'h0800) && (ver == 8'h45) && (proto == 8'd17) && (dip == BIP) &&
          (ulen >= 16'd8) && (!PORT_FILT || (dport == 16'd1234));
    n = (cut >= 0) ? cut : fb.size();
    for (int i = 0; i < n; i++) begin
      e.en   = acc && (plen > 0) && (i >= hdr) && (i < hdr + plen);
      e.data = fb[i];
      e.done = acc && (i == hdr + plen - 1);
      e.num  = 16'(plen);
      @(negedge clk);
      bus.gmii_rx_dv = 1'b1;
      bus.gmii_rxd   = fb[i];
      exp_q.push_back(e);
    end
    if (ifg > 0) idle(ifg);
  endtask

  task automatic group_start();
    strobes = 0;
    dones   = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rxd   = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset rec_en", bus.rec_en, 64'd0);
    chk("reset rec_pkt_done", bus.rec_pkt_done, 64'd0);
    chk("reset rec_byte_num", bus.rec_byte_num, 64'd0);
    chk("reset src_mac", bus.src_mac, 64'd0);
    chk("reset src_ip", bus.src_ip, 64'd0);
    idle(2);

    // 1) unicast, 4-byte payload 11 22 33 44
    group_start();
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd12, 8'h11, 8'h11, -1, 4);
    chk("t1 strobes", strobes, 64'd4);
    chk("t1 dones", dones, 64'd1);
    chk("t1 byte_num", bus.rec_byte_num, 64'd4);
    chk("t1 src_ip", bus.src_ip, 64'hc0a80166);
    chk("t1 src_mac", bus.src_mac, 64'ha0b1c2d3e4f5);

    // 2) broadcast 100-byte counting payload, then a wrong dest MAC
    group_start();
    send_frame(7, 48'hffff_ffff_ffff, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd108, 8'h00, 8'h01, -1, 3);
    chk("t2 strobes", strobes, 64'd100);
    chk("t2 byte_num", bus.rec_byte_num, 64'd100);
    group_start();
    send_frame(7, 48'h00_11_22_33_44_56, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd12, 8'h01, 8'h01, -1, 3);
    chk("t2 badmac strobes", strobes, 64'd0);
    chk("t2 badmac dones", dones, 64'd0);
    chk("t2 badmac byte_num", bus.rec_byte_num, 64'd100);

    // 3) wrong EtherType / protocol / dest IP, then a good frame, 1-cycle IFG each
    group_start();
    send_frame(7, BMAC, 16'h0806, 8'h45, 8'd17, BIP, 16'd1234, 16'd12, 8'h01, 8'h01, -1, 1);
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd6, BIP, 16'd1234, 16'd12, 8'h01, 8'h01, -1, 1);
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, 32'hc0a8017c, 16'd1234, 16'd12, 8'h01, 8'h01, -1, 1);
    chk("t3 filtered strobes", strobes, 64'd0);
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd14, 8'ha0, 8'h01, -1, 3);
    chk("t3 strobes", strobes, 64'd6);
    chk("t3 dones", dones, 64'd1);
    chk("t3 byte_num", bus.rec_byte_num, 64'd6);

    // 4) dv dropped after 10 of 64 payload bytes, then a normal frame
    group_start();
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd72, 8'h40, 8'h03, 60, 1);
    idle(2);
    chk("t4 abort strobes", strobes, 64'd10);
    chk("t4 abort dones", dones, 64'd0);
    chk("t4 abort byte_num", bus.rec_byte_num, 64'd6);
    group_start();
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd20, 8'hf0, 8'h01, -1, 2);
    chk("t4 next strobes", strobes, 64'd12);
    chk("t4 next byte_num", bus.rec_byte_num, 64'd12);

    // 5) short preamble, udp_len<8, udp_len==8
    group_start();
    send_frame(5, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd12, 8'h01, 8'h01, -1, 2);
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd4, 8'h01, 8'h01, -1, 2);
    chk("t5 drop strobes", strobes, 64'd0);
    chk("t5 drop dones", dones, 64'd0);
    chk("t5 drop byte_num", bus.rec_byte_num, 64'd12);
    send_frame(9, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd8, 8'h01, 8'h01, -1, 2);
    chk("t5 len8 strobes", strobes, 64'd0);
    chk("t5 len8 dones", dones, 64'd1);
    chk("t5 len8 byte_num", bus.rec_byte_num, 64'd0);

    // 6) dest port 5000
    group_start();
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd5000, 16'd16, 8'h30, 8'h01, -1, 2);
    chk("t6 port strobes", strobes, PORT_FILT ? 64'd0 : 64'd8);

    // reset asserted mid-payload while a strobe is being presented
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd40, 8'h70, 8'h01, 55, 0);
    @(negedge clk);
    chk("pre-reset rec_en", bus.rec_en, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst rec_en", bus.rec_en, 64'd0);
    chk("midrst rec_data", bus.rec_data, 64'd0);
    chk("midrst byte_num", bus.rec_byte_num, 64'd0);
    chk("midrst src_mac", bus.src_mac, 64'd0);
    chk("midrst src_ip", bus.src_ip, 64'd0);
    exp_q.delete();
    m_num = 16'd0; m_mac = 48'd0; m_ip = 32'd0;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rxd   = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    group_start();
    send_frame(7, BMAC, 16'h0800, 8'h45, 8'd17, BIP, 16'd1234, 16'd13, 8'h5a, 8'h11, -1, 3);
    chk("recover strobes", strobes, 64'd5);
    chk("recover byte_num", bus.rec_byte_num, 64'd5);
    chk("recover src_ip", bus.src_ip, 64'hc0a80166);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
